// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Holds the state encoding, the data/address widths and the legal latency range.
package dmem_responder_pkg;

  localparam int unsigned DATA_W  = 32'd16;
  localparam int unsigned ADDR_W  = 32'd16;
  localparam int unsigned LAT_MIN = 32'd1;
  localparam int unsigned LAT_MAX = 32'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte address bit 0 set means the word access is misaligned.
  function automatic logic is_unaligned(input logic [ADDR_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int unsigned AW = 32'd12,
  parameter int unsigned DW = 32'd16
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Storage write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request in flight, response pulse
// LATENCY cycles after acceptance, misaligned accesses flagged and suppressed.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 32'd2,
  parameter int unsigned MEM_AW  = 32'd12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_en,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  // LATENCY must lie in LAT_MIN..LAT_MAX; the counter is only 4 bits wide.
  localparam bit         LAT_ONE      = (LATENCY == 32'd1);
  localparam logic [3:0] LAT_CNT_INIT = (LATENCY >= 32'd2) ? 4'(LATENCY - 32'd2) : 4'd0;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic                w_accept;
  logic                w_access;
  logic                w_acc_wr;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic                w_acc_unaligned;
  logic                w_we;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused_addr;

  // Next-state, latency countdown and access-select decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    w_acc_wr    = r_wr;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (req_en) begin
          w_accept = 1'b1;
          if (LAT_ONE) begin
            // Single-cycle latency: access straight from the live request.
            w_access    = 1'b1;
            w_acc_wr    = req_wr;
            w_acc_addr  = req_addr;
            w_acc_wdata = req_wdata;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LAT_CNT_INIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_acc_unaligned = is_unaligned(w_acc_addr);
  assign w_we            = w_access & w_acc_wr & ~w_acc_unaligned & rst;
  assign w_unused_addr   = ^w_acc_addr;

  dmem_array #(
    .AW (MEM_AW),
    .DW (DATA_W)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (w_acc_addr[MEM_AW:1]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_rdata)
  );

  // State, request latches and registered response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_wr    <= req_wr;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      r_req_ready <= (w_state_nxt != ST_WAIT);
      r_rsp_valid <= w_access;
      r_rsp_rdata <= (w_access && !w_acc_wr && !w_acc_unaligned) ? w_rdata : '0;
      r_rsp_err   <= w_access && w_acc_unaligned;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic against a word-array reference model.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst;
  logic        req_en;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mdl_mem   [DEPTH];
  bit          mdl_known [DEPTH];

  dmem_responder #(.LATENCY(LAT), .MEM_AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_en    (req_en),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  function automatic void mdl_write(input logic [15:0] a, input logic [15:0] d);
    if (a[0] == 1'b0) begin
      mdl_mem[widx(a)]   = d;
      mdl_known[widx(a)] = 1'b1;
    end
  endfunction

  // Drives one request, waits for acceptance and the response; returns observations.
  task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd, output logic er,
                        output logic post_v, output logic [15:0] post_rd);
    int w;
    @(negedge clk);
    req_en = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 req_en = 1'b0;
    lat = 99; rd = 16'h0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
    @(negedge clk);
    post_v  = rsp_valid;
    post_rd = rsp_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_en = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got %h exp 0000", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", rsp_err); end
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] rd; logic er; logic pv; logic [15:0] prd;
    do_req(1'b1, 16'h00A4, 16'hBEEF, lat, rd, er, pv, prd);
    mdl_write(16'h00A4, 16'hBEEF);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL wr_latency got %0d exp %0d", lat, LAT); end
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL wr_rdata got %h exp 0000", rd); end
    do_req(1'b0, 16'h00A4, 16'h0000, lat, rd, er, pv, prd);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rd_latency got %0d exp %0d", lat, LAT); end
    n_checks++; if (rd !== mdl_mem[widx(16'h00A4)]) begin n_fail++; $display("FAIL rd_data got %h exp %h", rd, mdl_mem[widx(16'h00A4)]); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err got %b exp 0", er); end
    n_checks++; if (pv !== 1'b0 || prd !== 16'h0000) begin n_fail++; $display("FAIL rd_pulse_end got v=%b d=%h exp v=0 d=0000", pv, prd); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    req_en = 1'b1; req_wr = 1'b0; req_addr = 16'h00A4; req_wdata = 16'h0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_wait got rdy=%b v=%b exp rdy=0 v=0", req_ready, rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || rsp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL stall_resp1 got v=%b rdy=%b d=%h exp v=1 rdy=1 d=beef", rsp_valid, req_ready, rsp_rdata); end
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_wait2 got rdy=%b v=%b exp rdy=0 v=0", req_ready, rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_resp2 got v=%b exp 1", rsp_valid); end
    req_en = 1'b0;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_idle got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, req_ready); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] rd; logic er; logic pv; logic [15:0] prd;
    int np; int t0; int t1; logic [15:0] d0; logic [15:0] d1;
    do_req(1'b1, 16'h0010, 16'h1357, lat, rd, er, pv, prd); mdl_write(16'h0010, 16'h1357);
    do_req(1'b1, 16'h0012, 16'h2468, lat, rd, er, pv, prd); mdl_write(16'h0012, 16'h2468);
    np = 0; t0 = 99; t1 = 99; d0 = 16'h0; d1 = 16'h0;
    @(negedge clk);
    req_en = 1'b1; req_wr = 1'b0; req_addr = 16'h0010;
    @(posedge clk);
    #1 req_addr = 16'h0012;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (np == 0) begin t0 = c; d0 = rsp_rdata; end
        else begin t1 = c; d1 = rsp_rdata; req_en = 1'b0; end
        np++;
      end
    end
    req_en = 1'b0;
    n_checks++; if (np !== 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", np); end
    n_checks++; if (t1 - t0 !== LAT) begin n_fail++; $display("FAIL b2b_spacing got %0d exp %0d", t1 - t0, LAT); end
    n_checks++; if (d0 !== mdl_mem[widx(16'h0010)] || d1 !== mdl_mem[widx(16'h0012)]) begin n_fail++; $display("FAIL b2b_data got %h/%h exp %h/%h", d0, d1, mdl_mem[widx(16'h0010)], mdl_mem[widx(16'h0012)]); end
  endtask

  task automatic test_unaligned();
    int lat; logic [15:0] rd; logic er; logic pv; logic [15:0] prd;
    do_req(1'b1, 16'h0011, 16'h1234, lat, rd, er, pv, prd);
    mdl_write(16'h0011, 16'h1234);
    n_checks++; if (er !== 1'b1 || rd !== 16'h0000 || lat !== LAT) begin n_fail++; $display("FAIL unal_wr got err=%b d=%h lat=%0d exp err=1 d=0000 lat=%0d", er, rd, lat, LAT); end
    n_checks++; if (pv !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL unal_clear got v=%b err=%b exp 0/0", pv, rsp_err); end
    do_req(1'b0, 16'h0010, 16'h0000, lat, rd, er, pv, prd);
    n_checks++; if (rd !== mdl_mem[widx(16'h0010)] || er !== 1'b0) begin n_fail++; $display("FAIL unal_old got %h err=%b exp %h err=0", rd, er, mdl_mem[widx(16'h0010)]); end
    do_req(1'b0, 16'h0013, 16'h0000, lat, rd, er, pv, prd);
    n_checks++; if (rd !== 16'h0000 || er !== 1'b1) begin n_fail++; $display("FAIL unal_rd got %h err=%b exp 0000 err=1", rd, er); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] rd; logic er; logic pv; logic [15:0] prd;
    bit saw_v;
    do_req(1'b1, 16'h0020, 16'h1111, lat, rd, er, pv, prd); mdl_write(16'h0020, 16'h1111);
    saw_v = 1'b0;
    @(negedge clk);
    req_en = 1'b1; req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'h5555;
    @(posedge clk);
    #1 req_en = 1'b0; rst = 1'b0;
    repeat (2) begin @(negedge clk); if (rsp_valid) saw_v = 1'b1; end
    rst = 1'b1;
    repeat (3) begin @(negedge clk); if (rsp_valid) saw_v = 1'b1; end
    n_checks++; if (saw_v !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", saw_v); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", req_ready); end
    do_req(1'b0, 16'h0020, 16'h0000, lat, rd, er, pv, prd);
    n_checks++; if (rd !== mdl_mem[widx(16'h0020)]) begin n_fail++; $display("FAIL rstmid_data got %h exp %h", rd, mdl_mem[widx(16'h0020)]); end
  endtask

  task automatic test_alias();
    int lat; logic [15:0] rd; logic er; logic pv; logic [15:0] prd;
    do_req(1'b1, 16'h2000, 16'h0F0F, lat, rd, er, pv, prd); mdl_write(16'h2000, 16'h0F0F);
    do_req(1'b0, 16'h0000, 16'h0000, lat, rd, er, pv, prd);
    n_checks++; if (rd !== 16'h0F0F || rd !== mdl_mem[widx(16'h0000)]) begin n_fail++; $display("FAIL alias got %h exp 0f0f", rd); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] rd; logic er; logic pv; logic [15:0] prd;
    logic [15:0] a; logic [15:0] d; logic wr;
    for (int i = 0; i < 8; i++) begin
      a = 16'(i * 2 + 64);
      d = 16'($urandom);
      do_req(1'b1, a, d, lat, rd, er, pv, prd);
      mdl_write(a, d);
    end
    for (int i = 0; i < 40; i++) begin
      a  = 16'($urandom_range(0, 7) * 2 + 64) | 16'($urandom_range(0, 7) << 13);
      if ($urandom_range(0, 5) == 0) a[0] = 1'b1;
      wr = 1'($urandom_range(0, 1));
      d  = 16'($urandom);
      do_req(wr, a, d, lat, rd, er, pv, prd);
      n_checks++; if (lat !== LAT || er !== a[0]) begin n_fail++; $display("FAIL rnd_lat_err op%0d got lat=%0d err=%b exp lat=%0d err=%b", i, lat, er, LAT, a[0]); end
      if (!wr) begin
        n_checks++;
        if (a[0] ? (rd !== 16'h0000) : (rd !== mdl_mem[widx(a)])) begin
          n_fail++; $display("FAIL rnd_rdata op%0d addr=%h got %h exp %h", i, a, rd, a[0] ? 16'h0000 : mdl_mem[widx(a)]);
        end
      end else begin
        mdl_write(a, d);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mdl_known[i] = 1'b0; mdl_mem[i] = 16'h0; end
    test_reset();
    test_write_read();
    test_stall();
    test_back_to_back();
    test_unaligned();
    test_reset_mid();
    test_alias();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
